// File: rtl/accumulator_sequencer.sv
// ============================================================================
//  Module      : accumulator_sequencer
//  Description : Job sequencer that streams operands into an external
//                accumulator datapath and reads back sum, count and carry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accumulator_sequencer #(
   parameter logic [2:0] SEL_LSB   = 3'd0,
   parameter logic [2:0] SEL_MSB   = 3'd1,
   parameter logic [2:0] SEL_COUNT = 3'd2,
   parameter logic [2:0] SEL_CARRY = 3'd3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        op_valid,
   input  logic [7:0]  op_data,
   input  logic        op_last,
   output logic        op_ready,
   output logic        acc_reset,
   output logic        acc_load,
   output logic        acc_add,
   output logic [7:0]  acc_data_in,
   output logic [2:0]  acc_output_sel,
   input  logic [7:0]  acc_data_out,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [15:0] result_sum,
   output logic [7:0]  result_count,
   output logic        result_carry,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      CLEAR    = 4'd1,
      WAIT_OP  = 4'd2,
      LOAD     = 4'd3,
      ADD      = 4'd4,
      RD_LSB   = 4'd5,
      RD_MSB   = 4'd6,
      RD_CNT   = 4'd7,
      RD_CARRY = 4'd8,
      RESULT   = 4'd9
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] operand;
   logic       last_flag;
   logic [2:0] sel_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         operand        <= 8'd0;
         last_flag      <= 1'b0;
         acc_output_sel <= SEL_LSB;
         result_sum     <= 16'd0;
         result_count   <= 8'd0;
         result_carry   <= 1'b0;
      end else begin
         state          <= state_next;
         acc_output_sel <= sel_next;
         if (op_valid && op_ready) begin
            operand   <= op_data;
            last_flag <= op_last;
         end
         // Each read state samples the datapath word selected on entry.
         case (state)
            RD_LSB:   result_sum[7:0]  <= acc_data_out;
            RD_MSB:   result_sum[15:8] <= acc_data_out;
            RD_CNT:   result_count     <= acc_data_out;
            RD_CARRY: result_carry     <= acc_data_out[0];
            default:  ;
         endcase
      end
   end

   always_comb begin
      state_next   = state;
      op_ready     = 1'b0;
      acc_load     = 1'b0;
      acc_add      = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE:     if (start) state_next = CLEAR;
         CLEAR:    state_next = WAIT_OP;
         WAIT_OP: begin
            op_ready = 1'b1;
            if (op_valid) state_next = LOAD;
         end
         LOAD: begin
            acc_load   = 1'b1;
            state_next = ADD;
         end
         ADD: begin
            acc_add    = 1'b1;
            state_next = last_flag ? RD_LSB : WAIT_OP;
         end
         RD_LSB:   state_next = RD_MSB;
         RD_MSB:   state_next = RD_CNT;
         RD_CNT:   state_next = RD_CARRY;
         RD_CARRY: state_next = RESULT;
         RESULT: begin
            result_valid = 1'b1;
            if (result_ready) state_next = IDLE;
         end
         default:  state_next = IDLE;
      endcase
   end

   // The select register is loaded with the code of the state being entered.
   always_comb begin
      sel_next = SEL_LSB;
      case (state_next)
         RD_MSB:   sel_next = SEL_MSB;
         RD_CNT:   sel_next = SEL_COUNT;
         RD_CARRY: sel_next = SEL_CARRY;
         default:  sel_next = SEL_LSB;
      endcase
   end

   assign acc_reset   = reset | (state == CLEAR);
   assign acc_data_in = operand;
   assign busy        = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_accumulator_sequencer.sv
// ============================================================================
//  Module      : tb_accumulator_sequencer
//  Description : Directed bench for accumulator_sequencer with a behavioural
//                accumulator datapath attached to the acc_* ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accumulator_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op_valid = 1'b0;
   logic [7:0]  op_data = 8'd0;
   logic        op_last = 1'b0;
   logic        op_ready;
   logic        acc_reset;
   logic        acc_load;
   logic        acc_add;
   logic [7:0]  acc_data_in;
   logic [2:0]  acc_output_sel;
   logic [7:0]  acc_data_out;
   logic        result_valid;
   logic        result_ready = 1'b0;
   logic [15:0] result_sum;
   logic [7:0]  result_count;
   logic        result_carry;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   accumulator_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .op_valid       (op_valid),
      .op_data        (op_data),
      .op_last        (op_last),
      .op_ready       (op_ready),
      .acc_reset      (acc_reset),
      .acc_load       (acc_load),
      .acc_add        (acc_add),
      .acc_data_in    (acc_data_in),
      .acc_output_sel (acc_output_sel),
      .acc_data_out   (acc_data_out),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .result_sum     (result_sum),
      .result_count   (result_count),
      .result_carry   (result_carry),
      .busy           (busy)
   );

   // Accumulator datapath: load latches an operand, add sums it and bumps a
   // counter whose wrap sets a sticky carry.
   logic [15:0] dp_sum;
   logic [7:0]  dp_opnd;
   logic [7:0]  dp_cnt;
   logic        dp_cy;

   always_ff @(posedge clock) begin
      if (acc_reset) begin
         dp_sum  <= 16'd0;
         dp_opnd <= 8'd0;
         dp_cnt  <= 8'd0;
         dp_cy   <= 1'b0;
      end else begin
         if (acc_load) dp_opnd <= acc_data_in;
         if (acc_add) begin
            dp_sum <= dp_sum + {8'd0, dp_opnd};
            dp_cnt <= dp_cnt + 8'd1;
            if (dp_cnt == 8'hFF) dp_cy <= 1'b1;
         end
      end
   end

   always_comb begin
      acc_data_out = 8'd0;
      case (acc_output_sel)
         3'd0: acc_data_out = dp_sum[7:0];
         3'd1: acc_data_out = dp_sum[15:8];
         3'd2: acc_data_out = dp_cnt;
         3'd3: acc_data_out = {7'd0, dp_cy};
         default: acc_data_out = 8'd0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("clear_acc_reset", acc_reset, 1);
   endtask

   // Returns at the negedge after the handshake edge (state LOAD).
   task automatic send_op(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      while (op_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("op_ready_wait", op_ready, 1);
      op_valid = 1'b1;
      op_data  = d;
      op_last  = l;
      @(negedge clock);
      op_valid = 1'b0;
      op_last  = 1'b0;
   endtask

   task automatic finish_job(input string tag, input logic [15:0] s, input logic [7:0] c,
                             input logic cy);
      int n;
      n = 0;
      while (result_valid !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_valid"}, result_valid, 1);
      chk({tag, "_sum"}, result_sum, s);
      chk({tag, "_count"}, result_count, c);
      chk({tag, "_carry"}, result_carry, cy);
      result_ready = 1'b1;
      @(negedge clock);
      result_ready = 1'b0;
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_acc_reset", acc_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_op_ready", op_ready, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_load_add", {acc_load, acc_add}, 0);
      chk("rst_sel", acc_output_sel, 0);
      chk("rst_sum", result_sum, 0);
      chk("rst_count_carry", {result_count, result_carry}, 0);
      chk("rst_data_in", acc_data_in, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle_acc_reset", acc_reset, 0);

      // Three operands
      start_job();
      send_op(8'd10, 1'b0);
      send_op(8'd20, 1'b0);
      send_op(8'd30, 1'b1);
      chk("load_strobe", acc_load, 1);
      chk("load_data", acc_data_in, 30);
      @(negedge clock);
      chk("add_strobe", {acc_load, acc_add}, 2'b01);
      finish_job("j3", 16'd60, 8'd3, 1'b0);

      // 0xFF + 0xFF with exact latency
      start_job();
      send_op(8'hFF, 1'b0);
      send_op(8'hFF, 1'b1);
      chk("lat_load", result_valid, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("lat_early", result_valid, 0);
      end
      @(negedge clock);
      chk("lat_six", result_valid, 1);
      finish_job("jff", 16'h01FE, 8'd2, 1'b0);

      // Back-pressure on result, start during RESULT->IDLE ignored
      start_job();
      send_op(8'd5, 1'b1);
      repeat (6) @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", result_valid, 1);
         chk("hold_data", {result_sum, result_count, result_carry}, {16'd5, 8'd1, 1'b0});
         @(negedge clock);
      end
      result_ready = 1'b1;
      start = 1'b1;
      @(negedge clock);
      result_ready = 1'b0;
      start = 1'b0;
      chk("hold_idle", busy, 0);
      chk("hold_valid_drop", result_valid, 0);
      @(negedge clock);
      chk("start_ignored", busy, 0);

      // Reset mid-job then single-operand job
      start_job();
      send_op(8'd1, 1'b0);
      send_op(8'd2, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ready", op_ready, 0);
      start_job();
      send_op(8'd7, 1'b1);
      finish_job("j7", 16'd7, 8'd1, 1'b0);

      // Spurious start / op_valid
      op_valid = 1'b1;
      repeat (2) @(negedge clock);
      chk("idle_opvalid_busy", busy, 0);
      chk("idle_opvalid_strobes", {op_ready, acc_load, acc_add}, 0);
      op_valid = 1'b0;
      start_job();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("wait_start_ready", op_ready, 1);
      chk("wait_start_strobes", {acc_load, acc_add}, 0);
      send_op(8'd4, 1'b0);
      start = 1'b1;
      @(negedge clock);
      chk("add_start_strobe", acc_add, 1);
      @(negedge clock);
      start = 1'b0;
      chk("add_start_ready", op_ready, 1);
      chk("add_start_strobes", {acc_load, acc_add}, 0);
      send_op(8'd6, 1'b1);
      finish_job("jsp", 16'd10, 8'd2, 1'b0);

      // 256 operands of 1
      start_job();
      for (int i = 0; i < 256; i++) begin
         send_op(8'd1, (i == 255) ? 1'b1 : 1'b0);
      end
      finish_job("j256", 16'h0100, 8'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
